pipe_stage_buf: RTL and testbench

Parametrised pipeline-stage register that replaces the fixed per-stage latches (EX/MEM style) with a valid/ready handshake, a two-entry skid buffer, and separate flush and bubble semantics. It carries one data payload and one control bundle (write/read enables) per entry, and sits between any two pipeline stages of the core (ID/EX, EX/MEM, MEM/WB). Control bits are always zero on a bubble so downstream write enables can never fire spuriously.

---
 rtl/pipe_stage_buf.sv | 137 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with a valid/ready handshake, a two-entry skid buffer,
// flush and bubble handling. Optional stall counter: define PIPE_STAGE_STATS_EN.
module pipe_stage_buf #(
  parameter int DATA_W              = 69,
  parameter int CTRL_W              = 4,
  parameter int ZERO_DATA_ON_BUBBLE = 1,
  parameter int STALL_CNT_W         = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // _p0 is the main (output-facing) entry, _p1 the younger skid entry.
  logic [DATA_W-1:0] main_data_p0, skid_data_p1;
  logic [CTRL_W-1:0] main_ctrl_p0, skid_ctrl_p1;

  logic in_fire, out_fire;
  logic load_main_in, load_main_skid, load_skid;

  assign in_ready_o  = (state_q != SKID) && !rst_i;
  assign out_valid_o = (state_q != EMPTY);
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d      = FULL;
          load_main_in = 1'b1;
        end
      end
      FULL: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end else if (in_fire) begin
          state_d   = SKID;
          load_skid = 1'b1;
        end
      end
      SKID: begin
        if (out_fire) begin
          state_d        = FULL;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over every transition; anything handshaken this cycle is dropped.
    if (flush_i) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Stage boundary: main and skid registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= EMPTY;
      main_data_p0 <= '0;
      main_ctrl_p0 <= '0;
      skid_data_p1 <= '0;
      skid_ctrl_p1 <= '0;
    end else begin
      state_q <= state_d;
      if (flush_i) begin
        main_ctrl_p0 <= '0;
        skid_ctrl_p1 <= '0;
      end else begin
        if (load_main_in) begin
          main_data_p0 <= in_data_i;
          main_ctrl_p0 <= in_ctrl_i;
        end else if (load_main_skid) begin
          main_data_p0 <= skid_data_p1;
          main_ctrl_p0 <= skid_ctrl_p1;
        end
        if (load_skid) begin
          skid_data_p1 <= in_data_i;
          skid_ctrl_p1 <= in_ctrl_i;
        end
      end
    end
  end

  // Control is forced to zero on a bubble so downstream enables cannot fire.
  assign out_ctrl_o = out_valid_o ? main_ctrl_p0 : '0;
  assign out_data_o = ((ZERO_DATA_ON_BUBBLE != 0) && !out_valid_o) ? '0 : main_data_p0;

`ifdef PIPE_STAGE_STATS_EN
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [STALL_CNT_W-1:0] stall_cnt_q;

  // Counts output stall cycles; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (out_valid_o && !out_ready_i) begin
      stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: table of per-cycle vectors plus hand-written
// sequences for bubble hold, reset mid-stall and (with PIPE_STAGE_STATS_EN) the stall counter.
module tb_pipe_stage_buf;
  localparam int DW = 69;
  localparam int CW = 4;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_i, flush_i, in_valid_i, out_ready_i;
  logic [DW-1:0] in_data_i;
  logic [CW-1:0] in_ctrl_i;
  logic          in_ready_z, out_valid_z, in_ready_h, out_valid_h;
  logic [DW-1:0] out_data_z, out_data_h;
  logic [CW-1:0] out_ctrl_z, out_ctrl_h;
`ifdef PIPE_STAGE_STATS_EN
  logic [SW-1:0] stall_cnt_z, stall_cnt_h;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .ZERO_DATA_ON_BUBBLE(1), .STALL_CNT_W(SW)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_z),
    .in_data_i(in_data_i), .in_ctrl_i(in_ctrl_i),
    .out_valid_o(out_valid_z), .out_ready_i(out_ready_i),
    .out_data_o(out_data_z), .out_ctrl_o(out_ctrl_z)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt_o(stall_cnt_z)
`endif
  );

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .ZERO_DATA_ON_BUBBLE(0), .STALL_CNT_W(SW)) u_hold (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_h),
    .in_data_i(in_data_i), .in_ctrl_i(in_ctrl_i),
    .out_valid_o(out_valid_h), .out_ready_i(out_ready_i),
    .out_data_o(out_data_h), .out_ctrl_o(out_ctrl_h)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt_o(stall_cnt_h)
`endif
  );

  typedef struct {
    logic          rst;
    logic          flush;
    logic          iv;
    logic          ord;
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
    logic          e_valid;
    logic          e_ready;
    logic [DW-1:0] e_data;
    logic [CW-1:0] e_ctrl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, flush, iv, ord, input logic [DW-1:0] d, input logic [CW-1:0] c,
                     input logic ev, er, input logic [DW-1:0] ed, input logic [CW-1:0] ec);
    vec_t v;
    v.rst = rst; v.flush = flush; v.iv = iv; v.ord = ord; v.data = d; v.ctrl = c;
    v.e_valid = ev; v.e_ready = er; v.e_data = ed; v.e_ctrl = ec;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, flush, iv, ord, input logic [DW-1:0] d, input logic [CW-1:0] c);
    rst_i = rst; flush_i = flush; in_valid_i = iv; out_ready_i = ord; in_data_i = d; in_ctrl_i = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

    //  rst flush iv ord data      ctrl  | valid ready data     ctrl
    add(1, 0, 0, 0, 69'h0,   4'h0,   0, 0, 69'h0,   4'h0);
    add(1, 0, 1, 1, 69'h99,  4'hF,   0, 0, 69'h0,   4'h0);
    add(0, 0, 1, 1, 69'h1,   4'hF,   1, 1, 69'h1,   4'hF);
    add(0, 0, 1, 1, 69'h2,   4'hF,   1, 1, 69'h2,   4'hF);
    add(0, 0, 1, 1, 69'h3,   4'hF,   1, 1, 69'h3,   4'hF);
    add(0, 0, 1, 1, 69'h4,   4'hF,   1, 1, 69'h4,   4'hF);
    add(0, 0, 0, 1, 69'h0,   4'h0,   0, 1, 69'h0,   4'h0);
    // stall into skid: A, B, C
    add(0, 0, 1, 1, 69'hA,   4'h1,   1, 1, 69'hA,   4'h1);
    add(0, 0, 1, 0, 69'hB,   4'h2,   1, 0, 69'hA,   4'h1);
    add(0, 0, 1, 0, 69'hC,   4'h3,   1, 0, 69'hA,   4'h1);
    add(0, 0, 1, 1, 69'hC,   4'h3,   1, 1, 69'hB,   4'h2);
    add(0, 0, 1, 1, 69'hC,   4'h3,   1, 1, 69'hC,   4'h3);
    add(0, 0, 0, 1, 69'h0,   4'h0,   0, 1, 69'h0,   4'h0);
    // flush with full skid, then flush of a fired input
    add(0, 0, 1, 0, 69'hD,   4'h5,   1, 1, 69'hD,   4'h5);
    add(0, 0, 1, 0, 69'hE,   4'h6,   1, 0, 69'hD,   4'h5);
    add(0, 1, 1, 0, 69'hF0,  4'h7,   0, 1, 69'h0,   4'h0);
    add(0, 0, 0, 1, 69'h0,   4'h0,   0, 1, 69'h0,   4'h0);
    add(0, 1, 1, 1, 69'h11,  4'h9,   0, 1, 69'h0,   4'h0);
    add(0, 0, 0, 1, 69'h0,   4'h0,   0, 1, 69'h0,   4'h0);
    add(0, 0, 0, 1, 69'h0,   4'h0,   0, 1, 69'h0,   4'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].ord, vecs[i].data, vecs[i].ctrl);
      tick();
      chk($sformatf("vec%0d valid", i), {68'h0, out_valid_z}, {68'h0, vecs[i].e_valid});
      chk($sformatf("vec%0d ready", i), {68'h0, in_ready_z}, {68'h0, vecs[i].e_ready});
      chk($sformatf("vec%0d data", i), out_data_z, vecs[i].e_data);
      chk($sformatf("vec%0d ctrl", i), {65'h0, out_ctrl_z}, {65'h0, vecs[i].e_ctrl});
    end

    // Bubble with held data: the ZERO_DATA_ON_BUBBLE=0 instance keeps the last payload.
    drive(0, 0, 1, 1, 69'h55, 4'hF);
    tick();
    chk("hold accept data", out_data_h, 69'h55);
    drive(0, 0, 0, 1, 69'h0, 4'h0);
    tick();
    chk("hold bubble valid", {68'h0, out_valid_h}, 69'h0);
    chk("hold bubble data", out_data_h, 69'h55);
    chk("hold bubble ctrl", {65'h0, out_ctrl_h}, 69'h0);
    chk("zero bubble data", out_data_z, 69'h0);

    // Reset while in SKID.
    drive(0, 0, 1, 0, 69'h21, 4'h3);
    tick();
    drive(0, 0, 1, 0, 69'h22, 4'h4);
    tick();
    chk("skid ready", {68'h0, in_ready_z}, 69'h0);
    chk("skid valid", {68'h0, out_valid_z}, 69'h1);
    drive(1, 0, 0, 0, 69'h0, 4'h0);
    tick();
    chk("rst valid", {68'h0, out_valid_z}, 69'h0);
    chk("rst ctrl", {65'h0, out_ctrl_z}, 69'h0);
    chk("rst data", out_data_z, 69'h0);
    chk("rst hold data", out_data_h, 69'h0);
    chk("rst ready low", {68'h0, in_ready_z}, 69'h0);
    drive(0, 0, 0, 1, 69'h0, 4'h0);
    #1;
    chk("post rst ready", {68'h0, in_ready_z}, 69'h1);
    tick();
    chk("post rst valid", {68'h0, out_valid_z}, 69'h0);
    chk("post rst ready2", {68'h0, in_ready_z}, 69'h1);

`ifdef PIPE_STAGE_STATS_EN
    chk("cnt after rst", {65'h0, stall_cnt_z}, 69'h0);
    drive(0, 0, 1, 0, 69'h33, 4'h2);
    tick();
    chk("cnt at accept", {65'h0, stall_cnt_z}, 69'h0);
    drive(0, 0, 0, 0, 69'h0, 4'h0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 3) chk("cnt 3", {65'h0, stall_cnt_z}, 69'h3);
      if (k == 15) chk("cnt 15", {65'h0, stall_cnt_z}, 69'hF);
    end
    chk("cnt saturated", {65'h0, stall_cnt_z}, 69'hF);
    drive(0, 1, 0, 0, 69'h0, 4'h0);
    tick();
    chk("cnt after flush", {65'h0, stall_cnt_z}, 69'hF);
    chk("flush valid", {68'h0, out_valid_z}, 69'h0);
    drive(1, 0, 0, 0, 69'h0, 4'h0);
    tick();
    chk("cnt after reset", {65'h0, stall_cnt_z}, 69'h0);
    drive(0, 0, 0, 1, 69'h0, 4'h0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
